// File: rtl/reorder_buffer_pkg.sv
// Shared types, sizes and tag helpers for the two-wide reorder buffer.
// A tag is the entry index zero-extended to 8 bits; 8'hFF means "no tag".
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 32;
  localparam int IDX_W     = 5;
  localparam int DATA_W    = 64;
  localparam int TAG_W     = 8;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [IDX_W:0]    cnt_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [4:0]        areg_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam tag_t  RSTAG_NULL = 8'hFF;
  localparam areg_t ZERO_REG   = 5'h1f;

  function automatic tag_t make_tag(idx_t idx);
    return {3'b000, idx};
  endfunction

  // Upper tag bits must be zero for the tag to name a ROB entry at all.
  function automatic logic cdb_hit(tag_t tag, idx_t idx);
    return (tag != RSTAG_NULL) && (tag[TAG_W-1:IDX_W] == '0) && (tag[IDX_W-1:0] == idx);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB and retire signals of the reorder buffer, bundled with
// a master (pipeline side) and slave (ROB side) view.
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
;
  logic  flush_in;
  logic  inst1_valid_in, inst2_valid_in;
  areg_t inst1_dest_in,  inst2_dest_in;
  tag_t  inst1_tag_out,  inst2_tag_out;
  logic  rob_full_out,   rob_empty_out;
  tag_t  cdb1_tag_in,    cdb2_tag_in;
  data_t cdb1_value_in,  cdb2_value_in;
  logic  inst1_retire_valid_out, inst2_retire_valid_out;
  tag_t  inst1_retire_tag_out,   inst2_retire_tag_out;
  areg_t inst1_retire_dest_out,  inst2_retire_dest_out;
  data_t inst1_retire_value_out, inst2_retire_value_out;

  modport master (
    output flush_in, inst1_valid_in, inst2_valid_in, inst1_dest_in, inst2_dest_in,
           cdb1_tag_in, cdb2_tag_in, cdb1_value_in, cdb2_value_in,
    input  inst1_tag_out, inst2_tag_out, rob_full_out, rob_empty_out,
           inst1_retire_valid_out, inst2_retire_valid_out,
           inst1_retire_tag_out, inst2_retire_tag_out,
           inst1_retire_dest_out, inst2_retire_dest_out,
           inst1_retire_value_out, inst2_retire_value_out
  );

  modport slave (
    input  flush_in, inst1_valid_in, inst2_valid_in, inst1_dest_in, inst2_dest_in,
           cdb1_tag_in, cdb2_tag_in, cdb1_value_in, cdb2_value_in,
    output inst1_tag_out, inst2_tag_out, rob_full_out, rob_empty_out,
           inst1_retire_valid_out, inst2_retire_valid_out,
           inst1_retire_tag_out, inst2_retire_tag_out,
           inst1_retire_dest_out, inst2_retire_dest_out,
           inst1_retire_value_out, inst2_retire_value_out
  );

endinterface

// File: rtl/reorder_buffer_rob_entry.sv
// One reorder-buffer entry: valid/done/dest/value plus its own match
// against both CDB broadcasts. Flush beats allocate beats clear beats CDB.
module reorder_buffer_rob_entry
  import reorder_buffer_pkg::*;
#(
  parameter idx_t IDX = '0
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  alloc_i,
  input  areg_t alloc_dest_i,
  input  logic  clear_i,
  input  logic  flush_i,
  input  tag_t  cdb1_tag_i,
  input  data_t cdb1_value_i,
  input  tag_t  cdb2_tag_i,
  input  data_t cdb2_value_i,
  output logic  valid_o,
  output logic  done_o,
  output areg_t dest_o,
  output data_t value_o
);

  logic  valid_q, valid_d, done_q, done_d;
  areg_t dest_q,  dest_d;
  data_t value_q, value_d;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    dest_d  = dest_q;
    value_d = value_q;
    if (flush_i) begin
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else if (alloc_i) begin
      valid_d = 1'b1;
      done_d  = 1'b0;
      dest_d  = alloc_dest_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else if (valid_q && cdb_hit(cdb2_tag_i, IDX)) begin
      done_d  = 1'b1;
      value_d = cdb2_value_i;
    end else if (valid_q && cdb_hit(cdb1_tag_i, IDX)) begin
      done_d  = 1'b1;
      value_d = cdb1_value_i;
    end
  end

  // NOTE: the payload (dest/value) is reset as well, so retire data is never X after reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      dest_q  <= ZERO_REG;
      value_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      dest_q  <= dest_d;
      value_q <= value_d;
    end
  end

  assign valid_o = valid_q;
  assign done_o  = done_q;
  assign dest_o  = dest_q;
  assign value_o = value_q;

endmodule

// File: rtl/reorder_buffer.sv
// Two-wide, 32-entry circular reorder buffer: allocates tags at tail,
// completes from two CDBs, retires up to two in-order entries at head.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input logic             clock,
  input logic             reset,
  reorder_buffer_if.slave rob
);

  idx_t head_q, head_d, tail_q, tail_d, head_p1, idx1, idx2;
  cnt_t count_q, count_d;
  logic full_int, dispatch_ok, alloc1, alloc2, ret1, ret2;

  logic [ROB_DEPTH-1:0] ent_valid, ent_done;
  areg_t                ent_dest  [ROB_DEPTH];
  data_t                ent_value [ROB_DEPTH];

  // Full is judged on registered count only; a same-cycle retire does not free a slot early.
  assign full_int    = count_q > cnt_t'(ROB_DEPTH - 2);
  assign dispatch_ok = reset && !full_int && !rob.flush_in;
  assign alloc1      = dispatch_ok && rob.inst1_valid_in;
  assign alloc2      = dispatch_ok && rob.inst2_valid_in;
  assign idx1        = tail_q;
  assign idx2        = alloc1 ? tail_q + idx_t'(1) : tail_q;
  assign head_p1     = head_q + idx_t'(1);
  assign ret1        = reset && !rob.flush_in && ent_valid[head_q] && ent_done[head_q];
  assign ret2        = ret1 && ent_valid[head_p1] && ent_done[head_p1];

  for (genvar i = 0; i < ROB_DEPTH; i++) begin : g_entry
    localparam idx_t I = idx_t'(i);
    reorder_buffer_rob_entry #(.IDX(I)) u_entry (
      .clock        (clock),
      .reset        (reset),
      .alloc_i      ((alloc1 && idx1 == I) || (alloc2 && idx2 == I)),
      .alloc_dest_i ((alloc2 && idx2 == I) ? rob.inst2_dest_in : rob.inst1_dest_in),
      .clear_i      ((ret1 && head_q == I) || (ret2 && head_p1 == I)),
      .flush_i      (rob.flush_in),
      .cdb1_tag_i   (rob.cdb1_tag_in),
      .cdb1_value_i (rob.cdb1_value_in),
      .cdb2_tag_i   (rob.cdb2_tag_in),
      .cdb2_value_i (rob.cdb2_value_in),
      .valid_o      (ent_valid[i]),
      .done_o       (ent_done[i]),
      .dest_o       (ent_dest[i]),
      .value_o      (ent_value[i])
    );
  end

  always_comb begin
    rob.inst1_tag_out          = alloc1 ? make_tag(idx1) : RSTAG_NULL;
    rob.inst2_tag_out          = alloc2 ? make_tag(idx2) : RSTAG_NULL;
    rob.rob_full_out           = reset && full_int;
    rob.rob_empty_out          = !reset || (count_q == '0);
    rob.inst1_retire_valid_out = ret1;
    rob.inst2_retire_valid_out = ret2;
    rob.inst1_retire_tag_out   = ret1 ? make_tag(head_q)  : RSTAG_NULL;
    rob.inst2_retire_tag_out   = ret2 ? make_tag(head_p1) : RSTAG_NULL;
    rob.inst1_retire_dest_out  = ret1 ? ent_dest[head_q]   : ZERO_REG;
    rob.inst2_retire_dest_out  = ret2 ? ent_dest[head_p1]  : ZERO_REG;
    rob.inst1_retire_value_out = ret1 ? ent_value[head_q]  : '0;
    rob.inst2_retire_value_out = ret2 ? ent_value[head_p1] : '0;
  end

  always_comb begin
    head_d  = head_q + idx_t'(ret1) + idx_t'(ret2);
    tail_d  = tail_q + idx_t'(alloc1) + idx_t'(alloc2);
    count_d = count_q + cnt_t'(alloc1) + cnt_t'(alloc2) - cnt_t'(ret1) - cnt_t'(ret2);
    if (rob.flush_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a program-order queue model predicts
// tags, flags and retirements each cycle; a monitor compares them.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer_if rob_if ();
  reorder_buffer dut (.clock(clk), .reset(rst_n), .rob(rob_if));

  typedef struct {
    tag_t  tag;
    areg_t dest;
    logic  done;
    data_t value;
  } ent_s;

  typedef struct {
    tag_t  tag1, tag2;
    logic  full, empty;
    logic  rv1, rv2;
    tag_t  rt1, rt2;
    areg_t rd1, rd2;
    data_t rx1, rx2;
  } exp_s;

  ent_s        model_q[$];
  int unsigned model_tail = 0;
  exp_s        exp_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_cdb(input tag_t c, input data_t x);
    tag_t c_v;
    c_v = c;
    if (c_v != RSTAG_NULL && c_v[7:5] == 3'b000)
      foreach (model_q[i])
        if (model_q[i].tag == c_v) begin
          model_q[i].done  = 1'b1;
          model_q[i].value = x;
        end
  endtask

  // One clock of stimulus: drive, predict from the model, then advance the model past the edge.
  task automatic cyc(input logic rst, input logic fl, input logic v1, input areg_t d1,
                     input logic v2, input areg_t d2, input tag_t c1, input data_t x1,
                     input tag_t c2, input data_t x2);
    exp_s e;
    int   n;
    logic ok;
    @(negedge clk);
    rst_n                 = rst;
    rob_if.flush_in       = fl;
    rob_if.inst1_valid_in = v1;
    rob_if.inst1_dest_in  = d1;
    rob_if.inst2_valid_in = v2;
    rob_if.inst2_dest_in  = d2;
    rob_if.cdb1_tag_in    = c1;
    rob_if.cdb1_value_in  = x1;
    rob_if.cdb2_tag_in    = c2;
    rob_if.cdb2_value_in  = x2;

    e = '{default: '0};
    e.full  = rst && (model_q.size() >= ROB_DEPTH - 1);
    e.empty = !rst || (model_q.size() == 0);
    ok      = rst && !fl && (model_q.size() <= ROB_DEPTH - 2);
    e.tag1  = (ok && v1) ? tag_t'(model_tail % ROB_DEPTH) : RSTAG_NULL;
    e.tag2  = (ok && v2) ? tag_t'((model_tail + (v1 ? 1 : 0)) % ROB_DEPTH) : RSTAG_NULL;
    n = 0;
    if (rst && !fl && model_q.size() > 0 && model_q[0].done) n = 1;
    if (n == 1 && model_q.size() > 1 && model_q[1].done) n = 2;
    e.rv1 = (n >= 1);
    e.rv2 = (n == 2);
    e.rt1 = RSTAG_NULL;
    e.rt2 = RSTAG_NULL;
    if (n >= 1) begin
      e.rt1 = model_q[0].tag; e.rd1 = model_q[0].dest; e.rx1 = model_q[0].value;
    end
    if (n == 2) begin
      e.rt2 = model_q[1].tag; e.rd2 = model_q[1].dest; e.rx2 = model_q[1].value;
    end
    exp_q.push_back(e);

    if (!rst || fl) begin
      model_q.delete();
      model_tail = 0;
    end else begin
      apply_cdb(c1, x1);
      apply_cdb(c2, x2);
      repeat (n) void'(model_q.pop_front());
      if (e.tag1 != RSTAG_NULL) model_q.push_back('{tag: e.tag1, dest: d1, done: 1'b0, value: '0});
      if (e.tag2 != RSTAG_NULL) model_q.push_back('{tag: e.tag2, dest: d2, done: 1'b0, value: '0});
      model_tail = (model_tail + ((e.tag1 != RSTAG_NULL) ? 1 : 0) + ((e.tag2 != RSTAG_NULL) ? 1 : 0)) % ROB_DEPTH;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1, 0, 0, 5'd0, 0, 5'd0, RSTAG_NULL, '0, RSTAG_NULL, '0);
  endtask

  task automatic disp(input logic v1, input areg_t d1, input logic v2, input areg_t d2);
    cyc(1, 0, v1, d1, v2, d2, RSTAG_NULL, '0, RSTAG_NULL, '0);
  endtask

  task automatic cdb(input tag_t c1, input data_t x1, input tag_t c2, input data_t x2);
    cyc(1, 0, 0, 5'd0, 0, 5'd0, c1, x1, c2, x2);
  endtask

  task automatic flush();
    cyc(1, 1, 0, 5'd0, 0, 5'd0, RSTAG_NULL, '0, RSTAG_NULL, '0);
  endtask

  function automatic tag_t pick_tag(input int p_hit);
    int r;
    r = $urandom_range(99);
    if (r < p_hit && model_q.size() > 0) return model_q[$urandom_range(model_q.size() - 1)].tag;
    if (r < p_hit + 10) return tag_t'($urandom);
    return RSTAG_NULL;
  endfunction

  task automatic rnd(input int n, input int p_disp, input int p_hit, input int p_flush);
    tag_t c1, c2;
    for (int i = 0; i < n; i++) begin
      c1 = pick_tag(p_hit);
      c2 = pick_tag(p_hit);
      if (c2 == c1) c2 = RSTAG_NULL;
      cyc(1, ($urandom_range(999) < p_flush),
          ($urandom_range(99) < p_disp), areg_t'($urandom),
          ($urandom_range(99) < p_disp), areg_t'($urandom),
          c1, {$urandom, $urandom}, c2, {$urandom, $urandom});
    end
  endtask

  // Monitor: samples settled outputs mid-cycle and compares against the queued prediction.
  initial begin : monitor
    exp_s e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("inst1_tag", rob_if.inst1_tag_out, e.tag1);
        check("inst2_tag", rob_if.inst2_tag_out, e.tag2);
        check("rob_full", rob_if.rob_full_out, e.full);
        check("rob_empty", rob_if.rob_empty_out, e.empty);
        check("retire1_valid", rob_if.inst1_retire_valid_out, e.rv1);
        check("retire2_valid", rob_if.inst2_retire_valid_out, e.rv2);
        check("retire1_tag", rob_if.inst1_retire_tag_out, e.rt1);
        check("retire2_tag", rob_if.inst2_retire_tag_out, e.rt2);
        if (e.rv1) begin
          check("retire1_dest", rob_if.inst1_retire_dest_out, e.rd1);
          check("retire1_value", rob_if.inst1_retire_value_out, e.rx1);
        end
        if (e.rv2) begin
          check("retire2_dest", rob_if.inst2_retire_dest_out, e.rd2);
          check("retire2_value", rob_if.inst2_retire_value_out, e.rx2);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rob_if.flush_in       = 1'b0;
    rob_if.inst1_valid_in = 1'b0;
    rob_if.inst2_valid_in = 1'b0;
    rob_if.inst1_dest_in  = '0;
    rob_if.inst2_dest_in  = '0;
    rob_if.cdb1_tag_in    = RSTAG_NULL;
    rob_if.cdb2_tag_in    = RSTAG_NULL;
    rob_if.cdb1_value_in  = '0;
    rob_if.cdb2_value_in  = '0;

    // Reset with a pending dispatch: outputs must stay forced.
    repeat (2) cyc(0, 0, 1, 5'd3, 1, 5'd4, RSTAG_NULL, '0, RSTAG_NULL, '0);
    disp(1, 5'd3, 0, 5'd0);
    idle(1);

    // Dual dispatch, out-of-order completion, paired in-order retire.
    flush();
    disp(1, 5'd4, 1, 5'd5);
    cdb(8'h01, 64'd55, RSTAG_NULL, '0);
    cdb(8'h00, 64'd44, RSTAG_NULL, '0);
    idle(3);

    // Fill to full, attempt an ignored dispatch, free two, then wrap the tail.
    flush();
    for (int i = 0; i < 15; i++) disp(1, areg_t'(i), 1, 5'h1f);
    disp(1, 5'd7, 0, 5'd0);
    disp(1, 5'd8, 1, 5'd9);
    cdb(8'h00, 64'hA0, 8'h01, 64'hA1);
    idle(2);
    disp(1, 5'd10, 1, 5'd11);
    idle(1);

    // Simultaneous retire-two and allocate-two.
    flush();
    for (int i = 0; i < 5; i++) disp(1, areg_t'(i), 1, areg_t'(i + 8));
    cdb(8'h00, 64'hB0, 8'h01, 64'hB1);
    disp(1, 5'd20, 1, 5'd21);
    idle(1);

    // Flush while the head pair is retireable.
    flush();
    for (int i = 0; i < 3; i++) disp(1, areg_t'(i), 1, areg_t'(i + 3));
    cdb(8'h00, 64'hC0, 8'h01, 64'hC1);
    flush();
    disp(1, 5'd2, 0, 5'd0);

    // CDB corner cases: unallocated tag, upper-bit tag, idle, then head completion.
    cdb(8'h10, 64'hD0, RSTAG_NULL, 64'hD1);
    cdb(8'h20, 64'hD2, RSTAG_NULL, '0);
    idle(1);
    cdb(8'h00, 64'hD3, RSTAG_NULL, '0);
    idle(2);

    // Randomized traffic: fill-heavy, completion-heavy, then drain.
    rnd(400, 70, 20, 8);
    rnd(400, 40, 60, 8);
    rnd(120, 0, 80, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
